rotate_left_seq: RTL and testbench
==================================

Name: rotate_left_seq

Overview:
- Multi-cycle rotate-left unit: the opposite direction to the team's combinational right barrel rotator.
- Rotates the loaded word left by one bit per clock, `amt` times, and signals completion with a single-cycle `done` pulse.
- Feeding it a right-rotated word with the same `amt` returns the original word. Used as the low-area inverse path in datapath test and recovery logic.

Parameters:
- WIDTH, 8, data word width in bits (must be ≥ 2).
- AMT_W, 3, width of the rotate amount (2**AMT_W ≤ WIDTH).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request. Sampled on a rising edge when not busy.
- din  input  WIDTH  word to rotate. Captured with `start`.
- amt  input  AMT_W  left-rotate amount, 0..2**AMT_W-1. Captured with `start`.
- busy  output  1  high while rotation is in progress; `start` is ignored.
- done  output  1  one-cycle pulse; `dout` is valid.
- dout  output  WIDTH  rotated result. Held until the next accepted `start` completes.

Behaviour:
- Reset (async, any time, including mid-operation):
  - state=IDLE; busy=0, done=0, dout=0.
  - Internal shift register and counter cleared.
  - No partial result is ever presented.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - `start`=1 at edge t0 captures `din` into the shift register and `amt` into the counter.
  - amt≠0 → SHIFT. amt=0 → DONE.
- SHIFT:
  - Each edge: shift register becomes {sr[WIDTH-2:0], sr[WIDTH-1]}; counter decrements.
  - When the counter reaches 0 on this edge → DONE, and `dout` loads the rotated value on the same edge.
  - busy=1 for the whole state. `start`, `din` and `amt` are ignored.
- DONE:
  - done=1 for exactly one cycle; busy=0.
  - `start`=1 in this cycle is accepted exactly as in IDLE (back-to-back operation). Otherwise → IDLE.
- Latency: `start` sampled at edge t0 → done high in the cycle following edge t0+amt. For amt=0 that is the cycle right after t0.
- dout is registered:
  - It changes only on the edge entering DONE.
  - It stays stable through IDLE and through the next operation's SHIFT cycles.
- Result: dout = (din << amt) | (din >> (WIDTH-amt)), modulo WIDTH. amt=0 gives dout=din.
- Width rule: no carry or sign handling. Pure rotation; bit count is preserved.
- Unknown or illegal state encodings recover to IDLE.

Test Plan:
- Reset, then start with din=8'hB4, amt=3 → busy high for 3 cycles; done pulses 1 cycle in the cycle after edge t0+3; dout=8'hA5.
- din=8'h3C, amt=0 → busy never asserts; done in the cycle after t0; dout=8'h3C.
- din=8'h01, amt=7 → dout=8'h80 after 7 shift cycles. Then din=8'h96, amt=3 (the right-rotate of 8'hB4 by 3) → dout=8'hB4, confirming the round trip.
- Op with din=8'hB4, amt=5; pulse `start` with din=8'hFF, amt=1 during busy → ignored; dout=8'h96; no extra done pulse.
- Assert reset on the second SHIFT cycle of din=8'hB4, amt=6 → immediately busy=0, done=0, dout=0; no done after release. A new start din=8'h0F, amt=4 → dout=8'hF0.
- Start din=8'h81, amt=1 → done; assert start in the done cycle with din=8'h12, amt=2 → second done 2 cycles later, dout=8'h48; the first result 8'h03 is held until then.

Source files
------------

// File: rtl/rotate_left_seq.sv
// Multi-cycle rotate-left unit: rotates a captured word left by one bit per clock,
// `amt` times, then pulses `done` with the registered result on `dout`.
module rotate_left_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AMT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  input  logic [AMT_W-1:0] amt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sr;
  logic [AMT_W-1:0] r_cnt;

  logic [WIDTH-1:0] w_rot;
  logic             w_last;

  assign w_rot  = {r_sr[WIDTH-2:0], r_sr[WIDTH-1]};
  assign w_last = (r_cnt == AMT_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      dout    <= '0;
    end else begin
      case (r_state)
        // DONE accepts a new start exactly like IDLE, giving back-to-back operation.
        S_IDLE, S_DONE: begin
          busy <= 1'b0;
          done <= 1'b0;
          if (start) begin
            r_sr  <= din;
            r_cnt <= amt;
            if (amt == '0) begin
              r_state <= S_DONE;
              done    <= 1'b1;
              dout    <= din;
            end else begin
              r_state <= S_SHIFT;
              busy    <= 1'b1;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_SHIFT: begin
          r_sr  <= w_rot;
          r_cnt <= r_cnt - AMT_W'(1);
          if (w_last) begin
            r_state <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            dout    <= w_rot;
          end
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rotate_left_seq.sv
// Directed bench for rotate_left_seq: expected results are queued at each start
// and compared against dout when done pulses.
module tb_rotate_left_seq;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned AMT_W = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] din;
  logic [AMT_W-1:0] amt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] dout;

  int compared   = 0;
  int mismatched = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] last_dout;

  rotate_left_seq #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .din   (din),
    .amt   (amt),
    .busy  (busy),
    .done  (done),
    .dout  (dout)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] d, input int unsigned a);
    int unsigned s;
    s = a % WIDTH;
    if (s == 0) return d;
    return (d << s) | (d >> (WIDTH - s));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the first post-accept cycle.
  task automatic start_op(input logic [WIDTH-1:0] d, input logic [AMT_W-1:0] a);
    start = 1'b1;
    din   = d;
    amt   = a;
    exp_q.push_back(rotl(d, a));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    din   = '0;
    amt   = '0;
  endtask

  // Counts busy cycles until done, checking dout stays held; returns at the done negedge.
  task automatic wait_done(input string tag, input int exp_cycles);
    int cycles;
    logic [WIDTH-1:0] e;
    cycles = 0;
    while (!done && cycles < 40) begin
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_hold"}, 32'(dout), 32'(last_dout));
      cycles++;
      @(negedge clk);
    end
    check({tag, "_latency"}, 32'(cycles), 32'(exp_cycles));
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_dout"}, 32'(dout), 32'(e));
    end else begin
      check({tag, "_queue_empty"}, 32'd0, 32'd1);
    end
    last_dout = dout;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    din   = '0;
    amt   = '0;
    last_dout = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // B4 rotl 3 = A5
    start_op(8'hB4, 3'd3);
    wait_done("b4_3", 3);
    check("b4_3_const", 32'(last_dout), 32'hA5);
    @(negedge clk);
    check("b4_3_single_pulse", 32'(done), 32'd0);
    check("b4_3_idle_hold", 32'(dout), 32'hA5);

    // amt = 0: no busy, done right after t0
    start_op(8'h3C, 3'd0);
    wait_done("3c_0", 0);
    check("3c_0_const", 32'(last_dout), 32'h3C);
    @(negedge clk);

    start_op(8'h01, 3'd7);
    wait_done("01_7", 7);
    check("01_7_const", 32'(last_dout), 32'h80);
    @(negedge clk);

    // Round trip: 96 is B4 rotated right by 3
    start_op(8'h96, 3'd3);
    wait_done("96_3", 3);
    check("roundtrip_const", 32'(last_dout), 32'hB4);
    @(negedge clk);

    // start during busy is ignored
    start_op(8'hB4, 3'd5);
    start = 1'b1;
    din   = 8'hFF;
    amt   = 3'd1;
    check("ign_busy", 32'(busy), 32'd1);
    @(negedge clk);
    start = 1'b0;
    din   = '0;
    amt   = '0;
    wait_done("b4_5", 4);
    check("b4_5_const", 32'(last_dout), 32'h96);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("b4_5_no_extra_done", 32'(done), 32'd0);
      check("b4_5_no_extra_busy", 32'(busy), 32'd0);
      check("b4_5_idle_hold", 32'(dout), 32'h96);
    end

    // Reset asserted during the second SHIFT cycle
    start_op(8'hB4, 3'd6);
    check("mid_shift1_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("mid_shift2_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_dout", 32'(dout), 32'd0);
    exp_q.delete();
    last_dout = '0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("post_rst_no_done", 32'(done), 32'd0);
      check("post_rst_dout", 32'(dout), 32'd0);
    end
    start_op(8'h0F, 3'd4);
    wait_done("0f_4", 4);
    check("0f_4_const", 32'(last_dout), 32'hF0);
    @(negedge clk);

    // Back-to-back: new start in the done cycle
    start_op(8'h81, 3'd1);
    wait_done("81_1", 1);
    check("81_1_const", 32'(last_dout), 32'h03);
    start_op(8'h12, 3'd2);
    wait_done("12_2", 2);
    check("12_2_const", 32'(last_dout), 32'h48);
    @(negedge clk);
    check("12_2_single_pulse", 32'(done), 32'd0);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
